px_adc_capture_multi: RTL and testbench

Parametrised multi-channel serial pixel-ADC capture engine, successor to the fixed two-channel capture path in `imaging`. It drives one shared chip-select and serial clock to `N_CH` serial ADCs and shifts their frames in parallel. It optionally averages 2^k conversions per result and pushes packed per-channel results into a first-word-fall-through FIFO with ready/valid backpressure. It sits between the pixel-array sequencer, which issues `start`, and the frame-buffer writer, which consumes `out_*`.

---
 rtl/px_adc_capture_multi.sv | 187 ++++++++++++++++++
 tb/tb_px_adc_capture_multi.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/px_adc_capture_multi.sv
// Multi-channel serial pixel-ADC capture: shared cs/sclk, per-lane shift and 2^k accumulate,
// results packed per channel into a first-word-fall-through FIFO with overflow flag.

module px_adc_capture_multi_lane #(
  parameter int DATA_W = 12,
  parameter int ACC_W  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              din,
  input  logic              shift_en,
  input  logic              acc_en,
  input  logic              clr,
  input  logic [1:0]        k,
  output logic [DATA_W-1:0] result
);
  logic [DATA_W-1:0] sh;
  logic [ACC_W-1:0]  acc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      acc <= '0;
    end else begin
      if (shift_en) sh <= {sh[DATA_W-2:0], din};
      if (clr)         acc <= '0;
      else if (acc_en) acc <= acc + ACC_W'(sh);
    end
  end

  assign result = DATA_W'(acc >> k);
endmodule

module px_adc_capture_multi #(
  parameter int N_CH       = 2,
  parameter int DATA_W     = 12,
  parameter int LEAD_BITS  = 4,
  parameter int FRAME_BITS = 16,
  parameter int CLK_DIV    = 2,
  parameter int QUIET_CYC  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             avg_log2,
  input  logic                   continuous,
  input  logic                   clr_overflow,
  input  logic [N_CH-1:0]        adc_din,
  output logic                   adc_cs,
  output logic                   adc_sclk,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N_CH*DATA_W-1:0] out_data,
  output logic                   fifo_afull,
  output logic                   overflow,
  output logic [2:0]             tp_state
);
  localparam int OUT_W   = N_CH * DATA_W;
  localparam int ACC_W   = DATA_W + 3;
  localparam int TMR_MAX = (CLK_DIV > QUIET_CYC) ? CLK_DIV : QUIET_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int BIT_W   = $clog2(FRAME_BITS + 1);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE = 3'd0, CS_SETUP = 3'd1, SHIFT = 3'd2, QUIET = 3'd3, PUSH = 3'd4
  } state_t;

  state_t                           state, state_nxt;
  logic [TMR_W-1:0]                 tmr;
  logic [BIT_W-1:0]                 bitc;
  logic [3:0]                       conv;
  logic [1:0]                       k_q;
  logic                             accept, tmr_done, quiet_done, sample;
  logic                             shift_en, acc_en, acc_clr;
  logic                             cs_d, sclk_d, busy_d;
  logic [N_CH-1:0][DATA_W-1:0]      res;
  logic [FIFO_DEPTH-1:0][OUT_W-1:0] mem;
  logic [CNT_W-1:0]                 count, count_nxt, widx;
  logic                             pop, do_push, drop;

  assign accept     = (state == IDLE) && start;
  assign tmr_done   = (tmr == TMR_W'(CLK_DIV - 1));
  assign quiet_done = (tmr == TMR_W'(QUIET_CYC - 1));
  // din is captured on the edge that drives sclk low->high
  assign sample     = (state == SHIFT) && tmr_done && !adc_sclk;
  assign shift_en   = sample && (bitc >= BIT_W'(LEAD_BITS)) && (bitc < BIT_W'(LEAD_BITS + DATA_W));
  assign acc_en     = (state == QUIET) && quiet_done;
  assign acc_clr    = accept || (state == PUSH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = CS_SETUP;
      CS_SETUP: if (tmr_done) state_nxt = SHIFT;
      SHIFT:    if (tmr_done && adc_sclk && (bitc == BIT_W'(FRAME_BITS))) state_nxt = QUIET;
      QUIET:    if (quiet_done) state_nxt = ((conv + 4'd1) < (4'd1 << k_q)) ? CS_SETUP : PUSH;
      PUSH:     state_nxt = continuous ? CS_SETUP : IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cs_d   = !((state_nxt == CS_SETUP) || (state_nxt == SHIFT));
    busy_d = (state_nxt != IDLE);
    sclk_d = 1'b1;
    if (state_nxt == SHIFT) begin
      if (state != SHIFT) sclk_d = 1'b0;
      else if (tmr_done)  sclk_d = !adc_sclk;
      else                sclk_d = adc_sclk;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adc_cs   <= 1'b1;
      adc_sclk <= 1'b1;
      busy     <= 1'b0;
      tmr      <= '0;
      bitc     <= '0;
      conv     <= '0;
      k_q      <= '0;
    end else begin
      adc_cs   <= cs_d;
      adc_sclk <= sclk_d;
      busy     <= busy_d;
      tmr      <= ((state_nxt != state) || ((state == SHIFT) && tmr_done)) ? '0 : tmr + TMR_W'(1);
      if (state != SHIFT) bitc <= '0;
      else if (sample)    bitc <= bitc + BIT_W'(1);
      if (accept) k_q <= avg_log2;
      if (acc_clr)     conv <= '0;
      else if (acc_en) conv <= conv + 4'd1;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_lane
    px_adc_capture_multi_lane #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .din      (adc_din[c]),
      .shift_en (shift_en),
      .acc_en   (acc_en),
      .clr      (acc_clr),
      .k        (k_q),
      .result   (res[c])
    );
  end

  // Head always sits in mem[0] so out_data comes straight from a register
  assign pop       = out_valid && out_ready;
  assign do_push   = (state == PUSH) && ((count < CNT_W'(FIFO_DEPTH)) || pop);
  assign drop      = (state == PUSH) && !do_push;
  assign widx      = pop ? count - CNT_W'(1) : count;
  assign count_nxt = count + CNT_W'(do_push) - CNT_W'(pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem        <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      fifo_afull <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (pop) begin
        for (int i = 0; i < FIFO_DEPTH - 1; i++) mem[i] <= mem[i+1];
        mem[FIFO_DEPTH-1] <= '0;
      end
      if (do_push) mem[widx[AW-1:0]] <= res;
      count      <= count_nxt;
      out_valid  <= (count_nxt != '0);
      fifo_afull <= (count_nxt >= CNT_W'(FIFO_DEPTH - 1));
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  assign out_data = mem[0];
  assign tp_state = state;
endmodule

// File: tb/tb_px_adc_capture_multi.sv
// Directed-sequence bench for px_adc_capture_multi: random ADC frames, results predicted
// from the logged frames by plain averaging arithmetic.

module tb_px_adc_capture_multi;
  localparam int N_CH = 2, DATA_W = 12, LEAD = 4, FB = 16, CLK_DIV = 2, QUIET = 2, DEPTH = 4;
  localparam int T = CLK_DIV * (1 + 2 * FB) + QUIET;

  typedef logic [N_CH-1:0][FB-1:0] frame_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   start = 1'b0;
  logic [1:0]             avg_log2 = '0;
  logic                   continuous = 1'b0;
  logic                   clr_overflow = 1'b0;
  logic [N_CH-1:0]        adc_din;
  logic                   adc_cs, adc_sclk, busy, out_valid, fifo_afull, overflow;
  logic                   out_ready = 1'b0;
  logic [N_CH*DATA_W-1:0] out_data;
  logic [2:0]             tp_state;

  px_adc_capture_multi #(
    .N_CH(N_CH), .DATA_W(DATA_W), .LEAD_BITS(LEAD), .FRAME_BITS(FB),
    .CLK_DIV(CLK_DIV), .QUIET_CYC(QUIET), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .avg_log2(avg_log2), .continuous(continuous),
    .clr_overflow(clr_overflow), .adc_din(adc_din), .adc_cs(adc_cs), .adc_sclk(adc_sclk),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fifo_afull(fifo_afull), .overflow(overflow), .tp_state(tp_state)
  );

  always #5 clk = ~clk;

  // ADC model: each cs fall takes a forced frame set if queued, else random, and logs it
  frame_t force_q[$];
  frame_t log_q[$];
  frame_t cur = '0;
  int     force_rd = 0, rise_cnt = 0, base = 0, cs_low = 0, din_idx;
  int     n_cmp = 0, n_bad = 0;
  logic [N_CH*DATA_W-1:0] exp_q[$];

  always @(posedge adc_sclk) rise_cnt <= rise_cnt + 1;
  always @(posedge clk) if (!adc_cs) cs_low <= cs_low + 1;

  always @(negedge adc_cs) begin
    frame_t f;
    if (force_rd < force_q.size()) begin
      f = force_q[force_rd];
      force_rd <= force_rd + 1;
    end else begin
      for (int c = 0; c < N_CH; c++) f[c] = 16'($urandom);
    end
    cur  <= f;
    base <= rise_cnt;
    log_q.push_back(f);
  end

  always_comb begin
    din_idx = rise_cnt - base;
    for (int c = 0; c < N_CH; c++)
      adc_din[c] = (din_idx >= 0 && din_idx < FB) ? cur[c][FB-1-din_idx] : 1'b0;
  end

  function automatic logic [N_CH*DATA_W-1:0] expect_res(input int s, input int k);
    logic [N_CH*DATA_W-1:0] r = '0;
    for (int c = 0; c < N_CH; c++) begin
      int sum = 0;
      for (int j = 0; j < (1 << k); j++)
        sum += (int'(log_q[s+j][c]) >> (FB - LEAD - DATA_W)) & ((1 << DATA_W) - 1);
      r[c*DATA_W +: DATA_W] = DATA_W'(sum >> k);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [1:0] k, input logic cont);
    avg_log2 = k; continuous = cont; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] st);
    int n = 0;
    while (tp_state !== st && n < 3000) begin tick(); n++; end
    chk("wait_state", tp_state, st);
  endtask

  // returns cycles from the call until just after the PUSH edge
  task automatic wait_push(output int cyc);
    cyc = 0;
    while (tp_state !== 3'd4 && cyc < 3000) begin tick(); cyc++; end
    chk("push_wait", tp_state, 3'd4);
    tick(); cyc++;
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    foreach (exp_q[i]) begin
      chk(tag, out_data, exp_q[i]);
      tick();
    end
    out_ready = 1'b0;
    chk({tag, "_empty"}, out_valid, 1'b0);
    exp_q.delete();
  endtask

  initial begin
    int cyc, s, c0, r0;
    repeat (3) tick();
    chk("rst_cs", adc_cs, 1'b1);
    chk("rst_sclk", adc_sclk, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, '0);
    chk("rst_afull", fifo_afull, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_state", tp_state, 3'd0);
    reset = 1'b1;
    tick();

    // single conversion, k=0
    force_q.push_back({16'h0123, 16'h0ABC});
    c0 = cs_low; r0 = rise_cnt;
    do_start(2'd0, 1'b0);
    chk("t1_busy_rise", busy, 1'b1);
    wait_push(cyc);
    chk("t1_latency", cyc, T + 1);
    chk("t1_valid", out_valid, 1'b1);
    chk("t1_data", out_data, 24'h123ABC);
    chk("t1_cs_low", cs_low - c0, CLK_DIV * (1 + 2 * FB));
    chk("t1_sclk_rises", rise_cnt - r0, FB);
    chk("t1_busy_fall", busy, 1'b0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t1_pop", out_valid, 1'b0);

    // averaging k=2, avg_log2 changed mid-run must not matter
    s = log_q.size();
    for (int j = 0; j < 4; j++) force_q.push_back({16'($urandom), 16'hF100 + 16'(j)});
    do_start(2'd2, 1'b0);
    avg_log2 = 2'd0;
    wait_push(cyc);
    chk("t2_latency", cyc, 4 * T + 1);
    chk("t2_ch0", out_data[DATA_W-1:0], 12'h101);
    chk("t2_data", out_data, expect_res(s, 2));
    repeat (80) tick();
    chk("t2_idle", tp_state, 3'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t2_single_push", out_valid, 1'b0);

    // other averaging depths on random frames
    for (int k = 1; k <= 3; k += 2) begin
      s = log_q.size();
      do_start(2'(k), 1'b0);
      wait_push(cyc);
      chk("t7_latency", cyc, (1 << k) * T + 1);
      exp_q.push_back(expect_res(s, k));
      drain("t7_data");
    end

    // backpressure and overflow in continuous mode
    s = log_q.size();
    do_start(2'd0, 1'b1);
    for (int n = 1; n <= 5; n++) begin
      wait_push(cyc);
      chk("t3_valid", out_valid, 1'b1);
      chk("t3_afull", fifo_afull, logic'(n >= 3));
      chk("t3_ovf", overflow, logic'(n >= 5));
    end
    continuous = 1'b0;
    wait_push(cyc);
    chk("t3_stop", busy, 1'b0);
    for (int i = 0; i < 4; i++) exp_q.push_back(expect_res(s + i, 0));
    drain("t3_drain");

    // full FIFO with pop in the PUSH cycle
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("t4_clr", overflow, 1'b0);
    s = log_q.size();
    do_start(2'd0, 1'b1);
    for (int n = 1; n <= 4; n++) wait_push(cyc);
    continuous = 1'b0;
    wait_state(3'd4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("t4_no_ovf", overflow, 1'b0);
    chk("t4_afull", fifo_afull, 1'b1);
    for (int i = 1; i <= 4; i++) exp_q.push_back(expect_res(s + i, 0));
    drain("t4_drain");

    // reset mid-SHIFT with one result already queued
    do_start(2'd0, 1'b0);
    wait_push(cyc);
    chk("t5_pre_valid", out_valid, 1'b1);
    do_start(2'd0, 1'b0);
    cyc = 0;
    while ((rise_cnt - base) != 7 && cyc < 500) begin tick(); cyc++; end
    chk("t5_bit7", rise_cnt - base, 7);
    reset = 1'b0;
    #1;
    chk("t5_cs", adc_cs, 1'b1);
    chk("t5_sclk", adc_sclk, 1'b1);
    chk("t5_busy", busy, 1'b0);
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_state", tp_state, 3'd0);
    tick(); tick();
    reset = 1'b1;
    tick();
    s = log_q.size();
    do_start(2'd0, 1'b0);
    wait_push(cyc);
    chk("t5_latency", cyc, T + 1);
    chk("t5_data", out_data, expect_res(s, 0));
    exp_q.push_back(expect_res(s, 0));

    // start during SHIFT ignored; clr_overflow loses to a simultaneous drop
    s = log_q.size();
    do_start(2'd0, 1'b1);
    for (int n = 1; n <= 3; n++) wait_push(cyc);
    continuous = 1'b0;
    chk("t6_full", fifo_afull, 1'b1);
    wait_state(3'd2);
    start = 1'b1; tick(); start = 1'b0;
    wait_state(3'd4);
    clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
    chk("t6_ovf_set_wins", overflow, 1'b1);
    chk("t6_busy", busy, 1'b0);
    repeat (150) tick();
    chk("t6_no_restart", tp_state, 3'd0);
    chk("t6_ovf_hold", overflow, 1'b1);
    for (int i = 0; i < 3; i++) exp_q.push_back(expect_res(s + i, 0));
    drain("t6_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
